// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants and FSM state type for the instruction-fetch front end.
//   INST_NOP    - bubble instruction presented to decode
//   HOLD_IF     - hold level at and above which the fetch output is frozen
//   JUMP_ENABLE - active level of the jump/flush request
//   RST_ENABLE  - active level of the asynchronous reset
package inst_fetch_pkg;
    localparam logic [31:0] INST_NOP    = 32'h0000_0001;
    localparam logic [2:0]  HOLD_IF     = 3'd2;
    localparam logic        JUMP_ENABLE = 1'b1;
    localparam logic        RST_ENABLE  = 1'b0;
    typedef enum logic {S_IDLE, S_WAIT} fetch_state_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO holding fetched {addr, inst} pairs.
//   clk, rst (async, active-low)
//   push/din  - write an entry
//   pop/dout  - dout is the head; pop advances it
//   flush     - empties the FIFO, wins over push/pop
//   full, empty, count - occupancy status
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 64
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    // a push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push & ~flush) mem[wp] <= din;
    always_ff @(posedge clk or negedge rst)
        if (rst == RST_ENABLE) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + 1'b1 : wp;
            rp    <= do_pop ? rp + 1'b1 : rp;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: issues word fetches for pc_i, buffers returned instructions and feeds decode in order.
//   clk, rst (async, active-low)
//   pc_i, jump_flag_i, hold_flag_i, jtag_reset_flag_i - control from the PC/ctrl side
//   ibus_req_o, ibus_addr_o, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i - instruction bus
//   inst_o, inst_addr_o, inst_valid_o - registered instruction to decode
//   fetch_stall_o - PC must hold this cycle
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          jump_flag_i,
    input  logic [2:0]    hold_flag_i,
    input  logic          jtag_reset_flag_i,
    output logic          ibus_req_o,
    output logic [AW-1:0] ibus_addr_o,
    input  logic          ibus_gnt_i,
    input  logic          ibus_rvalid_i,
    input  logic [AW-1:0] ibus_rdata_i,
    output logic [AW-1:0] inst_o,
    output logic [AW-1:0] inst_addr_o,
    output logic          inst_valid_o,
    output logic          fetch_stall_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t    state, state_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic            drop, drop_n;
    logic            flush, space, push, pop, full, empty;
    logic [CW-1:0]   count;
    logic [2*AW-1:0] head;
    assign flush       = (jump_flag_i == JUMP_ENABLE) | jtag_reset_flag_i;
    // the outstanding fetch in WAIT already owns one FIFO slot
    assign space       = ~full & (state == S_IDLE | count < CW'(DEPTH - 1));
    assign pop         = ~flush & (hold_flag_i < HOLD_IF) & ~empty;
    assign ibus_addr_o = {pc_i[AW-1:2], 2'b00};
    assign fetch_stall_o = (ibus_req_o & ~ibus_gnt_i) | ~space | (state == S_WAIT);
    always_ff @(posedge clk or negedge rst)
        if (rst == RST_ENABLE) begin
            state  <= S_IDLE;
            addr_q <= '0;
            drop   <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            drop   <= drop_n;
        end
    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        drop_n     = drop;
        push       = 1'b0;
        ibus_req_o = 1'b0;
        if (state == S_IDLE) begin
            ibus_req_o = (rst != RST_ENABLE) & space & ~flush;
            if (ibus_req_o & ibus_gnt_i) begin
                state_n = S_WAIT;
                addr_n  = ibus_addr_o;
            end
        end else if (ibus_rvalid_i) begin
            // data for a flushed fetch (earlier or this cycle) is discarded
            push    = ~drop & ~flush;
            drop_n  = 1'b0;
            state_n = S_IDLE;
        end else if (flush) begin
            drop_n = 1'b1;
        end
    end
    inst_fifo #(.DEPTH(DEPTH), .W(2 * AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({addr_q, ibus_rdata_i}),
        .pop   (pop),
        .flush (flush),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // flush forces pop low, so the same path loads the bubble
    always_ff @(posedge clk or negedge rst)
        if (rst == RST_ENABLE) begin
            inst_o       <= AW'(INST_NOP);
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else if (flush || hold_flag_i < HOLD_IF) begin
            inst_o       <= pop ? head[AW-1:0] : AW'(INST_NOP);
            inst_addr_o  <= pop ? head[2*AW-1:AW] : '0;
            inst_valid_o <= pop;
        end
endmodule
